cla_mw_addsub_seq: RTL and testbench
====================================

Name: cla_mw_addsub_seq

Overview:
Multi-word add/subtract sequencer that sits directly upstream of the 64-bit carry-look-ahead adder and feeds it. It accepts a stream of 64-bit operand word pairs, least-significant word first. Each pair is driven into one cla_64bit instance, and the carry is chained between words through a register, giving arbitrary-precision add/sub up to MAX_WORDS words. Results leave on a registered valid/ready stream, with end-of-operation flags on the last word.

Parameters:
MAX_WORDS, 8, maximum words per operation; power of two, >=2.
IDX_W, 3, word-index width; must equal log2(MAX_WORDS).

Ports:
clk  in  1  clock; all logic on rising edge.
rst_n  in  1  synchronous active-low reset.
s_valid  in  1  input word pair valid.
s_ready  out  1  input ready.
s_a  in  64  operand A word.
s_b  in  64  operand B word.
s_sub  in  1  1 = A-B, 0 = A+B; sampled on the first word of an operation only.
s_last  in  1  marks the most-significant word.
m_valid  out  1  result valid.
m_ready  in  1  result consumer ready.
m_sum  out  64  result word.
m_idx  out  IDX_W  word index within the operation (0 = LSW).
m_last  out  1  final word of the operation.
m_cout  out  1  unsigned carry out of the MSW; for sub, 1 = no borrow. 0 unless m_last.
m_ovf  out  1  two's-complement overflow of the full-width result. 0 unless m_last.
m_zero  out  1  all result words zero. 0 unless m_last.
m_err  out  1  operation forcibly terminated at MAX_WORDS without s_last. 0 unless m_last.

Behaviour:
- Reset (rst_n=0 at clk edge):
  - All m_* outputs go to 0; state goes to IDLE.
  - carry_q=0, sub_q=0, idx_q=0, zero_q=1.
  - Any partial operation is discarded.
- Handshake:
  - Word accepted when s_valid & s_ready.
  - s_ready = !m_valid | m_ready (combinational).
  - Output held stable while m_valid & !m_ready.
  - Latency is exactly 1 cycle from accept to m_valid.
  - Full throughput of one word per cycle when m_ready=1.
- FSM:
  - IDLE: next accepted word is the first word.
  - BUSY: mid-operation.
  - IDLE -> BUSY on accept with end=0.
  - BUSY -> IDLE on accept with end=1.
  - IDLE stays IDLE on a single-word accept (end=1).
  - end = s_last | (idx == MAX_WORDS-1).
- Per accepted word:
  - sub_eff = (IDLE ? s_sub : sub_q).
  - b_eff = sub_eff ? ~s_b : s_b.
  - cin = IDLE ? s_sub : carry_q.
  - cla_64bit computes s_a + b_eff + cin.
  - Registered: m_sum <= sum; m_idx <= idx; m_last <= end.
  - carry_q <= cout; sub_q <= sub_eff.
  - idx_q <= end ? 0 : idx+1.
  - zero_q <= end ? 1 : (zero_in & (sum==0)), where zero_in = IDLE ? 1 : zero_q.
- Flags, registered only when end=1, else 0:
  - m_cout = cout.
  - m_ovf = (s_a[63] == b_eff[63]) & (sum[63] != s_a[63]).
  - m_zero = zero_in & (sum==0).
  - m_err = !s_last.
- Forced termination: the word after a forced end starts a new operation (idx 0, cin = s_sub, s_sub re-sampled). No input is dropped.
- s_sub on non-first words is ignored.
- Only accepted words advance state; a stalled s_valid=1 with s_ready=0 changes nothing.
- Single-word operation: a first word with s_last=1 produces idx=0, last=1, and all flags.

Test Plan:
- 128-bit add: (a=FFFF_FFFF_FFFF_FFFF, b=1), then (a=0, b=0, last) -> sum0=0/idx0, sum1=1/idx1/last, m_cout=0, m_ovf=0, m_zero=0.
- 128-bit sub: (a=0, b=1, sub=1), then (a=0, b=0, last) -> both words FFFF_FFFF_FFFF_FFFF, m_cout=0 (borrow), m_ovf=0, m_zero=0. Repeat with a=b=5 single word -> sum=0, m_cout=1, m_zero=1.
- Signed overflow: single word a=7FFF_FFFF_FFFF_FFFF, b=1, last -> sum=8000_0000_0000_0000, m_ovf=1, m_cout=0.
- Backpressure: stream 4-word add with m_ready=0 for 3 cycles mid-operation -> s_ready=0, m_* stable throughout, no word lost or duplicated, carry chain correct.
- MAX_WORDS=8: 9 words, none with s_last -> 8th output has m_last=1, m_err=1; 9th output has idx=0 with cin taken from its own s_sub.
- Reset mid-operation after 2 of 4 words (rst_n=0 for one cycle) -> m_valid=0, all flags 0; next word treated as first (idx 0, cin = s_sub).

Source files
------------

// File: rtl/cla_mw_addsub_seq_if.sv
// ----------------------------------------------------------------------------
// cla_mw_addsub_seq_if
//   Stream bundle for the multi-word add/subtract sequencer.
//   Input stream  (s_*): one 64-bit operand word pair per beat, LSW first.
//   Output stream (m_*): one 64-bit result word per beat. End-of-operation
//                        flags are valid on the beat with m_last=1.
//   Modports:
//     master - the environment: drives operand words and m_ready.
//     slave  - the sequencer: drives s_ready and the result stream.
// ----------------------------------------------------------------------------
interface cla_mw_addsub_seq_if #(
    parameter int IDX_W = 3
);
    logic             s_valid;
    logic             s_ready;
    logic [63:0]      s_a;
    logic [63:0]      s_b;
    logic             s_sub;
    logic             s_last;

    logic             m_valid;
    logic             m_ready;
    logic [63:0]      m_sum;
    logic [IDX_W-1:0] m_idx;
    logic             m_last;
    logic             m_cout;
    logic             m_ovf;
    logic             m_zero;
    logic             m_err;

    modport master (
        output s_valid, s_a, s_b, s_sub, s_last, m_ready,
        input  s_ready, m_valid, m_sum, m_idx, m_last, m_cout, m_ovf, m_zero, m_err
    );

    modport slave (
        input  s_valid, s_a, s_b, s_sub, s_last, m_ready,
        output s_ready, m_valid, m_sum, m_idx, m_last, m_cout, m_ovf, m_zero, m_err
    );
endinterface

// File: rtl/cla_mw_addsub_seq.sv
// ----------------------------------------------------------------------------
// cla_64bit
//   Combinational 64-bit carry-look-ahead adder: {cout, sum} = a + b + cin.
//   Three lookahead levels of radix 4: bits -> 4-bit blocks -> 16-bit
//   sections -> 64-bit word.
//   Ports: a, b (64) operands; cin carry in; sum (64) result; cout carry out.
// ----------------------------------------------------------------------------
module cla_64bit (
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic        cin,
    output logic [63:0] sum,
    output logic        cout
);
    // Radix-4 lookahead: carries into positions 0..4 from generate/propagate
    // of four lanes and an incoming carry, fully expanded (no ripple).
    function automatic logic [4:0] la4(input logic [3:0] g, input logic [3:0] p,
                                       input logic c);
        logic [4:0] r;
        r[0] = c;
        r[1] = g[0] | (p[0] & c);
        r[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c);
        r[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c);
        r[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (&p & c);
        return r;
    endfunction

    logic [63:0] g, p, c;
    logic [15:0] bg, bp, cb;
    logic [3:0]  sg, sp;
    logic [4:0]  csb;
    logic [4:0]  t;

    always_comb begin
        // NOTE: every variable assigned in always_comb gets a default first so
        // no path can leave it holding an old value (which would infer a latch).
        g   = a & b;
        p   = a ^ b;
        c   = '0;
        bg  = '0;
        bp  = '0;
        cb  = '0;
        sg  = '0;
        sp  = '0;
        csb = '0;
        t   = '0;

        // Block (4-bit) generate/propagate.
        for (int k = 0; k < 16; k++) begin
            t     = la4(g[4*k +: 4], p[4*k +: 4], 1'b0);
            bg[k] = t[4];
            bp[k] = &p[4*k +: 4];
        end
        // Section (16-bit) generate/propagate.
        for (int s = 0; s < 4; s++) begin
            t     = la4(bg[4*s +: 4], bp[4*s +: 4], 1'b0);
            sg[s] = t[4];
            sp[s] = &bp[4*s +: 4];
        end
        // Carries flow back down: word -> sections -> blocks -> bits.
        csb = la4(sg, sp, cin);
        for (int s = 0; s < 4; s++) begin
            t             = la4(bg[4*s +: 4], bp[4*s +: 4], csb[s]);
            cb[4*s +: 4]  = t[3:0];
        end
        for (int k = 0; k < 16; k++) begin
            t            = la4(g[4*k +: 4], p[4*k +: 4], cb[k]);
            c[4*k +: 4]  = t[3:0];
        end
    end

    assign sum  = p ^ c;
    assign cout = csb[4];
endmodule

// ----------------------------------------------------------------------------
// cla_mw_addsub_seq
//   Arbitrary-precision add/subtract sequencer. Operand word pairs arrive LSW
//   first; each pair goes through one cla_64bit and the carry is chained
//   between words in a register. Results leave one cycle after acceptance on
//   a registered valid/ready stream; the last word carries cout/ovf/zero/err.
//   An operation is forcibly ended after MAX_WORDS words (m_err=1).
//   Ports:
//     clk   - clock, rising edge
//     rst_n - synchronous active-low reset
//     bus   - cla_mw_addsub_seq_if.slave (s_* operand stream, m_* results)
// ----------------------------------------------------------------------------
module cla_mw_addsub_seq #(
    parameter int MAX_WORDS = 8,
    parameter int IDX_W     = 3
) (
    input logic                 clk,
    input logic                 rst_n,
    cla_mw_addsub_seq_if.slave  bus
);
    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t state_q, state_d;

    // Operation context carried between words.
    logic             carry_q;
    logic             sub_q;
    logic [IDX_W-1:0] idx_q;
    logic             zero_q;

    // Registered output stream.
    logic             m_valid_q;
    logic [63:0]      m_sum_q;
    logic [IDX_W-1:0] m_idx_q;
    logic             m_last_q;
    logic             m_cout_q;
    logic             m_ovf_q;
    logic             m_zero_q;
    logic             m_err_q;

    logic        accept;
    logic        is_first;
    logic        word_end;
    logic        sub_eff;
    logic [63:0] b_eff;
    logic        cin;
    logic [63:0] sum;
    logic        cout;
    logic        zero_in;
    logic        sum_zero;
    logic        ovf;

    // The output register can take a new word whenever it is empty or being
    // drained this cycle.
    assign bus.s_ready = !m_valid_q || bus.m_ready;
    assign accept      = bus.s_valid && bus.s_ready;

    assign is_first = (state_q == IDLE);
    // A word closes the operation either on s_last or when it fills the last
    // index slot; the following word then starts afresh.
    assign word_end = bus.s_last || (idx_q == IDX_W'(MAX_WORDS - 1));

    // Subtraction is A + ~B + 1: the +1 enters as the carry into the LSW.
    assign sub_eff = is_first ? bus.s_sub : sub_q;
    assign b_eff   = sub_eff ? ~bus.s_b : bus.s_b;
    assign cin     = is_first ? bus.s_sub : carry_q;

    cla_64bit u_cla (
        .a    (bus.s_a),
        .b    (b_eff),
        .cin  (cin),
        .sum  (sum),
        .cout (cout)
    );

    assign zero_in  = is_first || zero_q;
    assign sum_zero = (sum == 64'd0);
    // Signed overflow is judged on the MSW: operand signs agree, result differs.
    assign ovf      = (bus.s_a[63] == b_eff[63]) && (sum[63] != bus.s_a[63]);

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state is written with non-blocking assignments so
        // every register samples pre-edge values regardless of statement order.
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state: only an accepted word moves the FSM.
    always_comb begin
        state_d = state_q;
        if (accept) state_d = word_end ? IDLE : BUSY;
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            carry_q   <= 1'b0;
            sub_q     <= 1'b0;
            idx_q     <= '0;
            zero_q    <= 1'b1;
            m_valid_q <= 1'b0;
            m_sum_q   <= '0;
            m_idx_q   <= '0;
            m_last_q  <= 1'b0;
            m_cout_q  <= 1'b0;
            m_ovf_q   <= 1'b0;
            m_zero_q  <= 1'b0;
            m_err_q   <= 1'b0;
        end else if (accept) begin
            carry_q   <= cout;
            sub_q     <= sub_eff;
            idx_q     <= word_end ? '0 : idx_q + IDX_W'(1);
            zero_q    <= word_end ? 1'b1 : (zero_in && sum_zero);
            m_valid_q <= 1'b1;
            m_sum_q   <= sum;
            m_idx_q   <= idx_q;
            m_last_q  <= word_end;
            // Operation flags exist only on the final word.
            m_cout_q  <= word_end && cout;
            m_ovf_q   <= word_end && ovf;
            m_zero_q  <= word_end && zero_in && sum_zero;
            m_err_q   <= word_end && !bus.s_last;
        end else if (bus.m_ready) begin
            m_valid_q <= 1'b0;
        end
    end

    assign bus.m_valid = m_valid_q;
    assign bus.m_sum   = m_sum_q;
    assign bus.m_idx   = m_idx_q;
    assign bus.m_last  = m_last_q;
    assign bus.m_cout  = m_cout_q;
    assign bus.m_ovf   = m_ovf_q;
    assign bus.m_zero  = m_zero_q;
    assign bus.m_err   = m_err_q;
endmodule

// File: tb/tb_cla_mw_addsub_seq.sv
// ----------------------------------------------------------------------------
// tb_cla_mw_addsub_seq
//   Scoreboard bench: each operation's expected result words are computed from
//   full-width integer arithmetic and queued; a monitor pops and compares every
//   result beat the consumer takes, and checks stability while stalled.
// ----------------------------------------------------------------------------
module tb_cla_mw_addsub_seq;
    localparam int MAX_WORDS = 8;
    localparam int IDX_W     = 3;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    cla_mw_addsub_seq_if #(.IDX_W(IDX_W)) bus ();

    cla_mw_addsub_seq #(
        .MAX_WORDS (MAX_WORDS),
        .IDX_W     (IDX_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [63:0] sum;
        int          idx;
        bit          last;
        bit          cout;
        bit          ovf;
        bit          zero;
        bit          err;
    } exp_t;

    exp_t        exp_q[$];
    logic [63:0] op_a[MAX_WORDS];
    logic [63:0] op_b[MAX_WORDS];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          rdy_mode = 0;   // 0: always ready, 1: random, 2: held low
    bit          gap_en   = 0;   // random idle cycles between input words

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Consumer ready, changed just after each rising edge.
    initial begin
        bus.m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       bus.m_ready = 1'b1;
                1:       bus.m_ready = ($urandom_range(0, 3) != 0);
                default: bus.m_ready = 1'b0;
            endcase
        end
    end

    // Monitor: a beat is taken at the next rising edge when valid & ready.
    initial begin
        bit          stalled;
        logic [63:0] h_sum;
        logic [7:0]  h_ctl;
        exp_t        e;
        stalled = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stalled = 0;
                continue;
            end
            if (stalled) begin
                check("hold_valid", bus.m_valid, 1);
                check("hold_sum", bus.m_sum, h_sum);
                check("hold_ctl", {bus.m_idx, bus.m_last, bus.m_cout, bus.m_ovf,
                                   bus.m_zero, bus.m_err}, h_ctl);
            end
            stalled = 0;
            if (bus.m_valid && !bus.m_ready) begin
                check("stall_s_ready", bus.s_ready, 0);
                stalled = 1;
                h_sum   = bus.m_sum;
                h_ctl   = {bus.m_idx, bus.m_last, bus.m_cout, bus.m_ovf, bus.m_zero, bus.m_err};
            end else if (bus.m_valid && bus.m_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_output: got sum %h idx %0d, expected nothing",
                             bus.m_sum, bus.m_idx);
                end else begin
                    e = exp_q.pop_front();
                    check("sum",  bus.m_sum,  e.sum);
                    check("idx",  bus.m_idx,  e.idx);
                    check("last", bus.m_last, e.last);
                    check("cout", bus.m_cout, e.cout);
                    check("ovf",  bus.m_ovf,  e.ovf);
                    check("zero", bus.m_zero, e.zero);
                    check("err",  bus.m_err,  e.err);
                end
            end
        end
    end

    // Drive one word (caller is at a falling edge); returns at a falling edge.
    task automatic send_word(input logic [63:0] a, input logic [63:0] b,
                             input logic sub, input logic last);
        int budget;
        bus.s_valid = 1'b1;
        bus.s_a     = a;
        bus.s_b     = b;
        bus.s_sub   = sub;
        bus.s_last  = last;
        budget = 0;
        while (!bus.s_ready && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        if (!bus.s_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: s_ready stayed %b, expected 1", bus.s_ready);
            bus.s_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    // Operation of n words from op_a/op_b; only the first send_n are issued.
    // Reference: the whole operand is one 64*n-bit integer.
    task automatic issue_op(input int n, input bit sub, input bit mark_last, input int send_n);
        logic [575:0] a_full, b_full, r_full, mask;
        int           w;
        bit           cout, ovf, zero, sa, sb, sr;
        exp_t         e;
        w      = 64 * n;
        a_full = '0;
        b_full = '0;
        for (int i = 0; i < n; i++) begin
            a_full[64*i +: 64] = op_a[i];
            b_full[64*i +: 64] = op_b[i];
        end
        mask = (576'd1 << w) - 576'd1;
        if (sub) begin
            r_full = (a_full - b_full) & mask;
            cout   = (a_full >= b_full);
        end else begin
            r_full = a_full + b_full;
            cout   = r_full[w];
            r_full = r_full & mask;
        end
        sa   = a_full[w-1];
        sb   = b_full[w-1];
        sr   = r_full[w-1];
        ovf  = sub ? (sa != sb && sr != sa) : (sa == sb && sr != sa);
        zero = (r_full == '0);
        for (int i = 0; i < send_n; i++) begin
            e.sum  = r_full[64*i +: 64];
            e.idx  = i;
            e.last = (i == n - 1);
            e.cout = e.last && cout;
            e.ovf  = e.last && ovf;
            e.zero = e.last && zero;
            e.err  = e.last && !mark_last;
            exp_q.push_back(e);
        end
        for (int i = 0; i < send_n; i++) begin
            // s_sub on later words is noise that must be ignored.
            send_word(op_a[i], op_b[i], (i == 0) ? sub : 1'($urandom_range(0, 1)),
                      mark_last && (i == n - 1));
            if (gap_en && $urandom_range(0, 3) == 0) begin
                bus.s_valid = 1'b0;
                repeat ($urandom_range(1, 2)) @(negedge clk);
            end
        end
        bus.s_valid = 1'b0;
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        while (exp_q.size() != 0 && budget < 1000) begin
            @(negedge clk);
            budget++;
        end
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d results outstanding, expected 0", exp_q.size());
            exp_q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    function automatic logic [63:0] rand_word();
        case ($urandom_range(0, 5))
            0:       return 64'd0;
            1:       return '1;
            2:       return 64'd1;
            3:       return 64'h8000_0000_0000_0000;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        bus.s_valid = 1'b0;
        bus.s_a     = '0;
        bus.s_b     = '0;
        bus.s_sub   = 1'b0;
        bus.s_last  = 1'b0;
        rst_n       = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset state.
        check("rst_m_valid", bus.m_valid, 0);
        check("rst_s_ready", bus.s_ready, 1);
        check("rst_flags", {bus.m_last, bus.m_cout, bus.m_ovf, bus.m_zero, bus.m_err}, 0);

        // 128-bit add with carry across words.
        op_a[0] = '1;    op_b[0] = 64'd1;
        op_a[1] = '0;    op_b[1] = '0;
        issue_op(2, 0, 1, 2);
        // 128-bit subtract with borrow through every word.
        op_a[0] = '0;    op_b[0] = 64'd1;
        op_a[1] = '0;    op_b[1] = '0;
        issue_op(2, 1, 1, 2);
        // Single-word subtract to zero.
        op_a[0] = 64'd5; op_b[0] = 64'd5;
        issue_op(1, 1, 1, 1);
        // Signed overflow.
        op_a[0] = 64'h7FFF_FFFF_FFFF_FFFF; op_b[0] = 64'd1;
        issue_op(1, 0, 1, 1);
        drain();

        // Backpressure mid-operation.
        for (int i = 0; i < 4; i++) begin
            op_a[i] = rand_word();
            op_b[i] = rand_word();
        end
        fork
            issue_op(4, 0, 1, 4);
            begin
                repeat (2) @(posedge clk);
                rdy_mode = 2;
                repeat (3) @(posedge clk);
                rdy_mode = 0;
            end
        join
        drain();

        // Forced end at MAX_WORDS, then the 9th word opens a subtract.
        for (int i = 0; i < MAX_WORDS; i++) begin
            op_a[i] = rand_word();
            op_b[i] = rand_word();
        end
        issue_op(MAX_WORDS, 0, 0, MAX_WORDS);
        op_a[0] = 64'd3; op_b[0] = 64'd7;
        op_a[1] = 64'd9; op_b[1] = 64'd2;
        issue_op(2, 1, 1, 2);
        drain();

        // Reset after 2 of 4 words; the last result is still in the register.
        for (int i = 0; i < 4; i++) begin
            op_a[i] = rand_word();
            op_b[i] = rand_word();
        end
        issue_op(4, 0, 1, 2);
        rst_n = 1'b0;
        @(posedge clk);
        #2;
        check("midrst_m_valid", bus.m_valid, 0);
        check("midrst_flags", {bus.m_last, bus.m_cout, bus.m_ovf, bus.m_zero, bus.m_err}, 0);
        exp_q.delete();
        rst_n = 1'b1;
        @(negedge clk);
        op_a[0] = 64'd10; op_b[0] = 64'd4;
        op_a[1] = 64'd0;  op_b[1] = 64'd0;
        issue_op(2, 1, 1, 2);
        drain();

        // Randomized operations with input gaps and random backpressure.
        gap_en   = 1;
        rdy_mode = 1;
        for (int k = 0; k < 40; k++) begin
            int  n;
            bit  ml;
            n  = $urandom_range(1, MAX_WORDS);
            ml = (n < MAX_WORDS) ? 1'b1 : 1'($urandom_range(0, 1));
            for (int i = 0; i < n; i++) begin
                op_a[i] = rand_word();
                op_b[i] = rand_word();
            end
            issue_op(n, 1'($urandom_range(0, 1)), ml, n);
        end
        rdy_mode = 0;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
